interrupt_sequencer: RTL and testbench

- Controls the fetch side of the 5-stage pipeline when an external interrupt arrives.
- On an accepted interrupt it freezes PC and the F/D buffer, then waits for the in-flight instructions to drain.
- It then injects three push micro-ops into Decode in place of fetched instructions: PC high, PC low, flags.
- Finally it steers Fetch to the interrupt vector and releases the pipeline.
- It sits beside the HDU: its pc_enb and f_d_enb are ANDed with the HDU/CU enables. Its injected instruction is muxed ahead of the F/D buffer input.

---
 rtl/interrupt_sequencer_pkg.sv | 63 ++++++
 rtl/interrupt_sequencer_if.sv | 30 +++
 rtl/interrupt_sequencer_request_latch.sv | 39 +++
 rtl/interrupt_sequencer.sv | 87 ++++++++
 tb/tb_interrupt_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and micro-op encodings for the interrupt sequencer.
// The OP_* values must track the Decode control-unit opcode table.
package int_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DRAIN      = 3'd1,
        ST_PUSH_PC_H  = 3'd2,
        ST_PUSH_PC_L  = 3'd3,
        ST_PUSH_FLAGS = 3'd4,
        ST_VECTOR     = 3'd5,
        ST_SETTLE     = 3'd6
    } state_t;

    localparam logic [15:0] OP_NOP        = 16'h0000;
    localparam logic [15:0] OP_PUSH_PC_H  = 16'hE001;
    localparam logic [15:0] OP_PUSH_PC_L  = 16'hE002;
    localparam logic [15:0] OP_PUSH_FLAGS = 16'hE003;

    typedef struct packed {
        logic pc_enb;
        logic f_d_enb;
        logic inject_valid;
        logic vector_sel;
        logic int_ack;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{pc_enb: 1'b1, f_d_enb: 1'b1, inject_valid: 1'b0,
                                    vector_sel: 1'b0, int_ack: 1'b0};

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            ST_DRAIN: begin
                c.pc_enb  = 1'b0;
                c.f_d_enb = 1'b0;
            end
            ST_PUSH_PC_H, ST_PUSH_PC_L, ST_PUSH_FLAGS: begin
                c.pc_enb       = 1'b0;
                c.f_d_enb      = 1'b0;
                c.inject_valid = 1'b1;
            end
            ST_VECTOR: begin
                c.f_d_enb    = 1'b0;
                c.vector_sel = 1'b1;
            end
            ST_SETTLE: c.int_ack = 1'b1;
            default:   c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] op_for_state(input state_t s);
        case (s)
            ST_PUSH_PC_H:  return OP_PUSH_PC_H;
            ST_PUSH_PC_L:  return OP_PUSH_PC_L;
            ST_PUSH_FLAGS: return OP_PUSH_FLAGS;
            default:       return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Request inputs and fetch-side control outputs of the interrupt sequencer.
interface interrupt_sequencer_if #(
    parameter int W = 16
);
    logic         interrupt;
    logic         int_enable;
    logic         hazard_stall;
    logic         branch_pending;
    logic         rti_done;
    logic         pc_enb;
    logic         f_d_enb;
    logic         inject_valid;
    logic [W-1:0] inject_instr;
    logic         vector_sel;
    logic         int_ack;
    logic         busy;
    logic [2:0]   state_dbg;

    modport master (
        input  interrupt, int_enable, hazard_stall, branch_pending, rti_done,
        output pc_enb, f_d_enb, inject_valid, inject_instr, vector_sel,
               int_ack, busy, state_dbg
    );

    modport slave (
        output interrupt, int_enable, hazard_stall, branch_pending, rti_done,
        input  pc_enb, f_d_enb, inject_valid, inject_instr, vector_sel,
               int_ack, busy, state_dbg
    );
endinterface

// File: rtl/interrupt_sequencer_request_latch.sv
// Edge detection, one-deep pending request and in-service tracking;
// produces the accept strobe consumed by the sequencer FSM.
module int_request_latch (
    input  logic clk,
    input  logic rst,
    input  logic interrupt,
    input  logic int_enable,
    input  logic hazard_stall,
    input  logic rti_done,
    input  logic idle,
    output logic accept
);
    logic int_prev_q, int_prev_d;
    logic pending_q, pending_d;
    logic in_service_q, in_service_d;
    logic edge_det;

    always_comb begin
        edge_det   = interrupt & ~int_prev_q;
        int_prev_d = interrupt;
        // An RTI retiring this cycle blocks a new accept until the flag has dropped.
        accept = idle & (pending_q | edge_det) & int_enable & ~in_service_q
                 & ~hazard_stall & ~rti_done;
        pending_d    = accept ? 1'b0 : (pending_q | edge_det);
        in_service_d = accept ? 1'b1 : (rti_done ? 1'b0 : in_service_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_prev_q   <= 1'b0;
            pending_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            int_prev_q   <= int_prev_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
        end
    end
endmodule

// File: rtl/interrupt_sequencer.sv
// Freezes fetch on an accepted interrupt, drains the pipe, injects three
// push micro-ops into Decode and then steers Fetch to the interrupt vector.
module interrupt_sequencer
    import int_pkg::*;
#(
    parameter int W            = 16,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    interrupt_sequencer_if.master bus
);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [W-1:0]     instr_q, instr_d;
    logic             accept;

    int_request_latch u_req (
        .clk          (clk),
        .rst          (rst),
        .interrupt    (bus.interrupt),
        .int_enable   (bus.int_enable),
        .hazard_stall (bus.hazard_stall),
        .rti_done     (bus.rti_done),
        .idle         (state_q == ST_IDLE),
        .accept       (accept)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_DRAIN: begin
                // A branch or flush in Execute restarts the quiet window.
                if (bus.branch_pending) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_PUSH_PC_H;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PUSH_PC_H:  state_d = ST_PUSH_PC_L;
            ST_PUSH_PC_L:  state_d = ST_PUSH_FLAGS;
            ST_PUSH_FLAGS: state_d = ST_VECTOR;
            ST_VECTOR:     state_d = ST_SETTLE;
            ST_SETTLE:     state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
        // Outputs are registered from the next state so they line up with state_q.
        ctrl_d  = decode_ctrl(state_d);
        instr_d = W'(op_for_state(state_d));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= CTRL_IDLE;
            instr_q <= W'(OP_NOP);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            instr_q <= instr_d;
        end
    end

    assign bus.pc_enb       = ctrl_q.pc_enb;
    assign bus.f_d_enb      = ctrl_q.f_d_enb;
    assign bus.inject_valid = ctrl_q.inject_valid;
    assign bus.vector_sel   = ctrl_q.vector_sel;
    assign bus.int_ack      = ctrl_q.int_ack;
    assign bus.inject_instr = instr_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench: per-cycle state and output checks for each interrupt scenario.
module tb_interrupt_sequencer;
    import int_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

    interrupt_sequencer_if #(.W(16)) bus ();

    interrupt_sequencer #(.W(16), .DRAIN_CYCLES(3), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected state 'rel' cycles after the accept cycle; push = cycle of PUSH_PC_H.
    function automatic logic [2:0] exp_st(input int rel, input int push);
        if (rel < 1)         return 3'd0;
        if (rel < push)      return 3'd1;
        if (rel == push)     return 3'd2;
        if (rel == push + 1) return 3'd3;
        if (rel == push + 2) return 3'd4;
        if (rel == push + 3) return 3'd5;
        if (rel == push + 4) return 3'd6;
        return 3'd0;
    endfunction

    // {pc_enb, f_d_enb, inject_valid, vector_sel, int_ack, busy, inject_instr}
    function automatic logic [21:0] exp_out(input logic [2:0] st);
        case (st)
            3'd1:    return {6'b000001, 16'h0000};
            3'd2:    return {6'b001001, 16'hE001};
            3'd3:    return {6'b001001, 16'hE002};
            3'd4:    return {6'b001001, 16'hE003};
            3'd5:    return {6'b100101, 16'h0000};
            3'd6:    return {6'b110011, 16'h0000};
            default: return {6'b110000, 16'h0000};
        endcase
    endfunction

    function automatic logic [21:0] obs_vec();
        return {bus.pc_enb, bus.f_d_enb, bus.inject_valid, bus.vector_sel,
                bus.int_ack, bus.busy, bus.inject_instr};
    endfunction

    task automatic rti_pulse();
        bus.rti_done = 1'b1;
        tick();
        bus.rti_done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.interrupt = 1'b0; bus.int_enable = 1'b1; bus.hazard_stall = 1'b0;
        bus.branch_pending = 1'b0; bus.rti_done = 1'b0;
        tick(); tick();
        checks++;
        if (obs_vec() !== exp_out(3'd0)) $display("FAIL reset_outputs got %h exp %h", obs_vec(), exp_out(3'd0));
        else passes++;
        checks++;
        if (bus.state_dbg !== 3'd0) $display("FAIL reset_state got %0d exp 0", bus.state_dbg);
        else passes++;
        #2 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.state_dbg !== 3'd0 || obs_vec() !== exp_out(3'd0))
                $display("FAIL post_reset_idle k=%0d got st=%0d out=%h exp st=0 out=%h", k, bus.state_dbg, obs_vec(), exp_out(3'd0));
            else passes++;
        end
        $display("[reset] checks=%0d passed=%0d", checks, passes);
    endtask

    task automatic test_basic();
        for (int k = 0; k <= 12; k++) begin
            bus.interrupt = (k == 0);
            checks++;
            if (bus.state_dbg !== exp_st(k, 4)) $display("FAIL basic_state k=%0d got %0d exp %0d", k, bus.state_dbg, exp_st(k, 4));
            else passes++;
            checks++;
            if (obs_vec() !== exp_out(exp_st(k, 4))) $display("FAIL basic_out k=%0d got %h exp %h", k, obs_vec(), exp_out(exp_st(k, 4)));
            else passes++;
            tick();
        end
        rti_pulse();
        $display("[basic] checks=%0d passed=%0d", checks, passes);
    endtask

    task automatic test_branch_drain();
        // Branches in cycles 2 and 3 reload the counter; PUSH_PC_H moves from 4 to 7.
        for (int k = 0; k <= 14; k++) begin
            bus.interrupt      = (k == 0);
            bus.branch_pending = (k == 2 || k == 3);
            checks++;
            if (bus.state_dbg !== exp_st(k, 7)) $display("FAIL branch_state k=%0d got %0d exp %0d", k, bus.state_dbg, exp_st(k, 7));
            else passes++;
            checks++;
            if (obs_vec() !== exp_out(exp_st(k, 7))) $display("FAIL branch_out k=%0d got %h exp %h", k, obs_vec(), exp_out(exp_st(k, 7)));
            else passes++;
            tick();
        end
        bus.branch_pending = 1'b0;
        rti_pulse();
        $display("[branch_drain] checks=%0d passed=%0d", checks, passes);
    endtask

    task automatic test_hazard_hold();
        for (int k = 0; k <= 13; k++) begin
            bus.interrupt    = (k == 0);
            bus.hazard_stall = (k <= 1);
            checks++;
            if (bus.state_dbg !== exp_st(k - 2, 4)) $display("FAIL hazard_state k=%0d got %0d exp %0d", k, bus.state_dbg, exp_st(k - 2, 4));
            else passes++;
            checks++;
            if (obs_vec() !== exp_out(exp_st(k - 2, 4))) $display("FAIL hazard_out k=%0d got %h exp %h", k, obs_vec(), exp_out(exp_st(k - 2, 4)));
            else passes++;
            tick();
        end
        rti_pulse();
        $display("[hazard_hold] checks=%0d passed=%0d", checks, passes);
    endtask

    task automatic test_back_to_back();
        logic [2:0] est;
        // Two extra edges during the first sequence merge into one pending request.
        for (int k = 0; k <= 50; k++) begin
            bus.interrupt = (k == 0 || k == 3 || k == 6);
            bus.rti_done  = (k == 33);
            est = (k < 34) ? exp_st(k, 4) : exp_st(k - 34, 4);
            checks++;
            if (bus.state_dbg !== est) $display("FAIL b2b_state k=%0d got %0d exp %0d", k, bus.state_dbg, est);
            else passes++;
            checks++;
            if (obs_vec() !== exp_out(est)) $display("FAIL b2b_out k=%0d got %h exp %h", k, obs_vec(), exp_out(est));
            else passes++;
            tick();
        end
        bus.interrupt = 1'b0;
        bus.rti_done  = 1'b0;
        rti_pulse();
        $display("[back_to_back] checks=%0d passed=%0d", checks, passes);
    endtask

    task automatic test_enable_gate();
        // Enable drops again mid-DRAIN; the running sequence must not abort.
        for (int k = 0; k <= 16; k++) begin
            bus.interrupt  = (k == 0);
            bus.int_enable = (k == 5 || k == 6);
            checks++;
            if (bus.state_dbg !== exp_st(k - 5, 4)) $display("FAIL enable_state k=%0d got %0d exp %0d", k, bus.state_dbg, exp_st(k - 5, 4));
            else passes++;
            checks++;
            if (obs_vec() !== exp_out(exp_st(k - 5, 4))) $display("FAIL enable_out k=%0d got %h exp %h", k, obs_vec(), exp_out(exp_st(k - 5, 4)));
            else passes++;
            tick();
        end
        bus.int_enable = 1'b1;
        rti_pulse();
        $display("[enable_gate] checks=%0d passed=%0d", checks, passes);
    endtask

    task automatic test_reset_mid_sequence();
        for (int k = 0; k <= 5; k++) begin
            bus.interrupt = (k == 0 || k == 2);
            checks++;
            if (bus.state_dbg !== exp_st(k, 4)) $display("FAIL midrst_state k=%0d got %0d exp %0d", k, bus.state_dbg, exp_st(k, 4));
            else passes++;
            if (k < 5) tick();
        end
        // Now in PUSH_PC_L with a merged request pending; reset must drop both.
        rst = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== exp_out(3'd0)) $display("FAIL midrst_async_out got %h exp %h", obs_vec(), exp_out(3'd0));
        else passes++;
        checks++;
        if (bus.state_dbg !== 3'd0) $display("FAIL midrst_async_state got %0d exp 0", bus.state_dbg);
        else passes++;
        #2 rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (bus.state_dbg !== 3'd0 || obs_vec() !== exp_out(3'd0))
                $display("FAIL midrst_idle k=%0d got st=%0d out=%h exp st=0 out=%h", k, bus.state_dbg, obs_vec(), exp_out(3'd0));
            else passes++;
        end
        $display("[reset_mid_sequence] checks=%0d passed=%0d", checks, passes);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_basic();
        test_branch_drain();
        test_hazard_hold();
        test_back_to_back();
        test_enable_gate();
        test_reset_mid_sequence();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
